ram_1p_host: RTL
================

// Module: ram_1p_host
// PURPOSE
// Host-side controller for a synchronous single-port RAM with 1-cycle read latency.
// - Optionally sweeps the whole RAM with InitValue after reset.
// - Then converts a valid/ready host request channel into RAM req/write/addr/wdata/wmask cycles.
// - Returns one in-order response per request through a 2-entry response buffer, so host
//   backpressure never loses read data.
// PARAMETERS
// Width        32     data/mask width in bits
// Depth        128    RAM words; Aw = $clog2(Depth)
// InitOnReset  1      1: zero-fill sweep after reset; 0: serve immediately
// InitValue    '0     Width-bit word written during the sweep
// PORTS
// clk_i              in   1      clock
// rst_i              in   1      synchronous active-high reset
// init_done_o        out  1      1 once sweep complete (or skipped); host may issue requests
// host_req_valid_i   in   1      request valid
// host_req_ready_o   out  1      request accepted when valid&ready
// host_write_i       in   1      1 write, 0 read
// host_addr_i        in   Aw     word address
// host_wdata_i       in   Width  write data
// host_wmask_i       in   Width  bit write mask
// host_rsp_valid_o   out  1      response valid
// host_rsp_ready_i   in   1      response consumed when valid&ready
// host_rsp_rdata_o   out  Width  read data (0 for writes/errors)
// host_rsp_err_o     out  1      1: address >= Depth, no RAM access made
// ram_req_o          out  1      to RAM req_i
// ram_write_o        out  1      to RAM write_i
// ram_addr_o         out  Aw     to RAM addr_i
// ram_wdata_o        out  Width  to RAM wdata_i
// ram_wmask_o        out  Width  to RAM wmask_i
// ram_rdata_i        in   Width  from RAM rdata_o, valid 1 cycle after read req
// BEHAVIOUR
// - Reset (rst_i=1 at clk edge): state=INIT (or RUN if InitOnReset=0), sweep ctr=0, buffer
//   empty, in-flight flag clear; init_done_o=0 (1 if InitOnReset=0), host_req_ready_o=0,
//   host_rsp_valid_o=0, rsp_rdata/err=0, ram_req_o=0. Reset mid-op discards all outstanding responses.
// - FSM INIT: each cycle ram_req_o=1, ram_write_o=1, addr=ctr, wdata=InitValue, wmask='1;
//   ctr counts 0..Depth-1 (ctr is Aw+1 bits, no wrap, non-power-of-2 Depth stops at Depth-1);
//   after writing Depth-1 -> DONE. Exactly Depth write cycles. host_req_ready_o=0 throughout.
// - DONE: one cycle, ram_req_o=0, then RUN; init_done_o registered 1 from RUN entry until reset.
// - RUN: occ = in-flight read (0/1) + buffered responses (0..2); host_req_ready_o = (occ<2),
//   registered/from state only, no comb path from host_rsp_ready_i.
// - Accept (valid&ready) with addr<Depth: same cycle ram_req_o=1, ram_write_o=host_write_i,
//   addr/wdata/wmask passed through combinationally. Otherwise ram_req_o=0.
// - Write: response (rdata=0, err=0) enters buffer next cycle. Read: in-flight set; next
//   cycle ram_rdata_i captured into buffer. Out-of-range: response (rdata=0, err=1) next cycle.
// - Response latency: accept at t -> host_rsp_valid_o earliest at t+1. Strict request order.
// - Buffer: 2-entry FIFO; push and pop in same cycle allowed; rsp outputs stable while
//   valid&!ready. Occ never exceeds 2; no overflow possible by ready rule.
// - Throughput: host_rsp_ready_i held 1 -> one request accepted every cycle.
// - ram_rdata_i is sampled only in the cycle after a host read; ignored otherwise.
// TESTING
// 1) InitOnReset=1, Depth=128: release reset -> 128 consecutive ram writes addr 0..127
//    mask '1 data 0, then ready/init_done_o=1 two cycles later; no host accept before.
// 2) Write 0xDEADBEEF @5 then read @5, rsp_ready=1 -> rsp #1 rdata 0 err 0, rsp #2
//    rdata 0xDEADBEEF at t+1 of read accept; back-to-back reads @0..9 -> 1 rsp/cycle, in order.
// 3) rsp_ready=0, issue reads @1,@2,@3 -> first two accepted, ready drops (occ=2), rsp data
//    held stable; raise rsp_ready -> @1,@2 delivered in order, then @3 accepted.
// 4) Depth=100, read addr 100 -> ram_req_o stays 0, rsp err=1 rdata 0; sweep ends at addr 99.
// 5) Assert rst_i with 2 buffered rsps and read in flight -> next cycle rsp_valid=0,
//    ready=0, sweep restarts at addr 0; no stale response ever emitted.
// 6) InitOnReset=0: first cycle after reset init_done_o=1, ready=1, no RAM writes issued.

Source files
------------

// File: rtl/ram_1p_host.sv
// ram_1p_host: host-side controller for a single-port synchronous RAM with
// 1-cycle read latency. After reset it can sweep every word with InitValue,
// then it turns a valid/ready request channel into RAM cycles and returns
// one in-order response per request through a 2-entry response buffer.
// Responses for a request accepted in cycle t are visible from cycle t+1:
// the pending response bypasses the buffer when the buffer is empty, and is
// only written into the buffer when the host does not take it that cycle.
module ram_1p_host #(
   parameter int               Width       = 32,
   parameter int               Depth       = 128,
   parameter bit               InitOnReset = 1'b1,
   parameter logic [Width-1:0] InitValue   = '0,
   localparam int              Aw          = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             init_done_o,
   input  logic             host_req_valid_i,
   output logic             host_req_ready_o,
   input  logic             host_write_i,
   input  logic [Aw-1:0]    host_addr_i,
   input  logic [Width-1:0] host_wdata_i,
   input  logic [Width-1:0] host_wmask_i,
   output logic             host_rsp_valid_o,
   input  logic             host_rsp_ready_i,
   output logic [Width-1:0] host_rsp_rdata_o,
   output logic             host_rsp_err_o,
   output logic             ram_req_o,
   output logic             ram_write_o,
   output logic [Aw-1:0]    ram_addr_o,
   output logic [Width-1:0] ram_wdata_o,
   output logic [Width-1:0] ram_wmask_o,
   input  logic [Width-1:0] ram_rdata_i
);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_DONE = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam logic [Aw:0] DepthW   = (Aw+1)'(Depth);
   localparam logic [Aw:0] LastAddr = (Aw+1)'(Depth - 1);

   state_e           state_q, state_d;
   logic [Aw:0]      ctr_q, ctr_d;
   logic             init_done_q, init_done_d;

   // The pending flags describe the request accepted in the previous cycle.
   logic             pend_q, pend_d;
   logic             pend_read_q, pend_read_d;
   logic             pend_err_q, pend_err_d;

   logic [Width-1:0] buf_rdata_q [2];
   logic [Width-1:0] buf_rdata_d [2];
   logic [1:0]       buf_err_q, buf_err_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;

   logic [1:0]       occ;
   logic             in_range;
   logic             req_ready;
   logic             accept;
   logic             push;
   logic             pop;
   logic [Width-1:0] pend_rdata;

   // Request-side handshake: ready depends only on registered occupancy.
   always_comb begin
      occ       = count_q + {1'b0, pend_q};
      in_range  = ({1'b0, host_addr_i} < DepthW);
      req_ready = !rst_i && (state_q == ST_RUN) && (occ < 2'd2);
      accept    = host_req_valid_i && req_ready;
   end

   assign host_req_ready_o = req_ready;
   assign init_done_o      = init_done_q;

   // RAM port mux: sweep writes during INIT, host pass-through during RUN.
   always_comb begin
      ram_req_o   = 1'b0;
      ram_write_o = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      ram_wmask_o = '0;
      case (state_q)
         ST_INIT: begin
            if (!rst_i) begin
               ram_req_o   = 1'b1;
               ram_write_o = 1'b1;
               ram_addr_o  = ctr_q[Aw-1:0];
               ram_wdata_o = InitValue;
               ram_wmask_o = '1;
            end
         end
         ST_RUN: begin
            ram_req_o   = accept && in_range;
            ram_write_o = host_write_i;
            ram_addr_o  = host_addr_i;
            ram_wdata_o = host_wdata_i;
            ram_wmask_o = host_wmask_i;
         end
         default: begin
            ram_req_o = 1'b0;
         end
      endcase
   end

   // Sequencing: sweep counter through every word, one idle cycle, then serve.
   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      init_done_d = init_done_q;
      case (state_q)
         ST_INIT: begin
            ctr_d = ctr_q + {{Aw{1'b0}}, 1'b1};
            if (ctr_q == LastAddr) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Response path: bypass the pending response when the buffer is empty,
   // otherwise present the buffer head; push whatever the host did not take.
   always_comb begin
      pend_rdata       = pend_read_q ? ram_rdata_i : '0;
      pop              = (count_q != 2'd0) && host_rsp_ready_i;
      push             = pend_q && !((count_q == 2'd0) && host_rsp_ready_i);

      host_rsp_valid_o = 1'b0;
      host_rsp_rdata_o = '0;
      host_rsp_err_o   = 1'b0;
      if (count_q != 2'd0) begin
         host_rsp_valid_o = 1'b1;
         host_rsp_rdata_o = buf_rdata_q[rd_ptr_q];
         host_rsp_err_o   = buf_err_q[rd_ptr_q];
      end else if (pend_q) begin
         host_rsp_valid_o = 1'b1;
         host_rsp_rdata_o = pend_rdata;
         host_rsp_err_o   = pend_err_q;
      end

      buf_rdata_d = buf_rdata_q;
      buf_err_d   = buf_err_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) begin
         buf_rdata_d[wr_ptr_q] = pend_rdata;
         buf_err_d[wr_ptr_q]   = pend_err_q;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      pend_d      = accept;
      pend_read_d = accept && !host_write_i && in_range;
      pend_err_d  = accept && !in_range;
   end

   // State registers; reset discards every outstanding response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= InitOnReset ? ST_INIT : ST_RUN;
         ctr_q       <= '0;
         init_done_q <= !InitOnReset;
         pend_q      <= 1'b0;
         pend_read_q <= 1'b0;
         pend_err_q  <= 1'b0;
         buf_rdata_q <= '{default: '0};
         buf_err_q   <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         init_done_q <= init_done_d;
         pend_q      <= pend_d;
         pend_read_q <= pend_read_d;
         pend_err_q  <= pend_err_d;
         buf_rdata_q <= buf_rdata_d;
         buf_err_q   <= buf_err_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

endmodule
